// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared constants, state encoding and helpers
// for the binary to BCD converter.
package bin_to_bcd_converter_pkg;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2
  } state_t;

  // Largest value representable in `digits` BCD digits
  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/response bundle between a producer
// and the binary to BCD converter.
interface bin_to_bcd_converter_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);

  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_data_ip;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_data_op;
  logic                  ovf;

  modport master (
    output start,
    output bin_data_ip,
    input  busy,
    input  done,
    input  bcd_data_op,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin_data_ip,
    output busy,
    output done,
    output bcd_data_op,
    output ovf
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction:
// add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // 4-bit add, no carry out; result stays <= 9+3 range
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to packed BCD
// converter with overflow flag and zero blanking.
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int         BIN_WIDTH  = 14,
  parameter int         DIGITS     = 4,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input logic                     clk_100mhz,
  input logic                     reset,
  bin_to_bcd_converter_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH);
  localparam int SW = BW + BIN_WIDTH;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(BIN_WIDTH - 1);
  localparam logic [31:0] MAX_V =
    32'(max_val(DIGITS));
  localparam logic [BW-1:0] ALL_BLANK =
    {DIGITS{BLANK_CODE}};
  localparam logic [BW-1:0] RST_BCD =
    BLANK_LZ ? {{(DIGITS-1){BLANK_CODE}}, 4'h0}
             : {BW{1'b0}};

  state_t                state_q, state_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovfn_q, ovfn_d;
  logic [BW-1:0]         out_q, out_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [BW-1:0]         corr;
  logic [SW-1:0]         shifted;
  logic [BW-1:0]         blanked;
  logic                  in_ovf;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
        .d_i (bcd_q[4*g +: 4]),
        .d_o (corr[4*g +: 4])
      );
    end
  endgenerate

  // One double-dabble step: corrected digits and
  // remaining binary shifted left together
  always_comb begin
    shifted = {corr, bin_q} << 1;
    in_ovf  = 32'(bus.bin_data_ip) > MAX_V;
  end

  // Leading-zero blanking, MS digit down;
  // digit 0 always shown
  always_comb begin
    logic lead;
    blanked = bcd_q;
    lead    = BLANK_LZ;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && bcd_q[4*i +: 4] == 4'h0) begin
        blanked[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // FSM next state, datapath and output updates
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovfn_d  = ovfn_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          bin_d   = bus.bin_data_ip;
          bcd_d   = '0;
          cnt_d   = '0;
          ovfn_d  = in_ovf;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        out_d   = ovfn_q ? ALL_BLANK : blanked;
        ovf_d   = ovfn_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, sync reset
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovfn_q  <= 1'b0;
      out_q   <= RST_BCD;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovfn_q  <= ovfn_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.bcd_data_op = out_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter with
// blanking on and off instances in parallel.
module tb_bin_to_bcd_converter;

  logic clk_100mhz;
  logic reset;

  int n_chk;
  int n_fail;

  bin_to_bcd_converter_if #(.BIN_WIDTH(14), .DIGITS(4)) if1 ();
  bin_to_bcd_converter_if #(.BIN_WIDTH(14), .DIGITS(4)) if0 ();

  bin_to_bcd_converter #(
    .BIN_WIDTH(14), .DIGITS(4), .BLANK_LZ(1'b1), .BLANK_CODE(4'hF)
  ) u_lz1 (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (if1.slave)
  );

  bin_to_bcd_converter #(
    .BIN_WIDTH(14), .DIGITS(4), .BLANK_LZ(1'b0), .BLANK_CODE(4'hF)
  ) u_lz0 (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (if0.slave)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] e1;
    logic [15:0] e0;
    logic        eo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [13:0] b);
    if1.start       = s;
    if0.start       = s;
    if1.bin_data_ip = b;
    if0.bin_data_ip = b;
  endtask

  task automatic chk_out(input string nm, input logic [15:0] e1,
                         input logic [15:0] e0, input logic eo);
    chk({nm, " bcd lz1"}, 32'(if1.bcd_data_op), 32'(e1));
    chk({nm, " bcd lz0"}, 32'(if0.bcd_data_op), 32'(e0));
    chk({nm, " ovf lz1"}, 32'(if1.ovf), 32'(eo));
    chk({nm, " ovf lz0"}, 32'(if0.ovf), 32'(eo));
  endtask

  // One full conversion from idle; checks latency and result
  task automatic convert(input logic [13:0] b, input logic [15:0] e1,
                         input logic [15:0] e0, input logic eo,
                         input string nm);
    int k;
    bit got;
    @(negedge clk_100mhz);
    drive(1'b1, b);
    @(posedge clk_100mhz);
    #1;
    drive(1'b0, 14'h2abc);
    chk({nm, " busy"}, 32'(if1.busy), 32'd1);
    got = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (if1.done) begin
        got = 1'b1;
        break;
      end
      if (k < 15 && (if1.bcd_data_op !== e1 || 1'b1)) begin
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no done within 40 edges", nm);
    end else begin
      chk({nm, " latency"}, 32'(k), 32'd15);
      chk({nm, " done lz0"}, 32'(if0.done), 32'd1);
      chk({nm, " busy@done"}, 32'(if1.busy), 32'd0);
      chk_out(nm, e1, e0, eo);
      @(posedge clk_100mhz);
      #1;
      chk({nm, " done pulse"}, 32'(if1.done), 32'd0);
      chk({nm, " held"}, 32'(if1.bcd_data_op), 32'(e1));
    end
  endtask

  initial begin
    int dn;
    int d1;
    int d2;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{14'd305,   16'hF305, 16'h0305, 1'b0};
    vecs[2] = '{14'd7,     16'hFFF7, 16'h0007, 1'b0};
    vecs[3] = '{14'd0,     16'hFFF0, 16'h0000, 1'b0};
    vecs[4] = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
    vecs[5] = '{14'd10000, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[6] = '{14'd42,    16'hFF42, 16'h0042, 1'b0};
    vecs[7] = '{14'd1000,  16'h1000, 16'h1000, 1'b0};
    vecs[8] = '{14'd16383, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[9] = '{14'd10,    16'hFF10, 16'h0010, 1'b0};

    // Reset for 3 cycles
    drive(1'b0, 14'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    chk("rst busy", 32'(if1.busy), 32'd0);
    chk("rst done", 32'(if1.done), 32'd0);
    chk_out("rst", 16'hFFF0, 16'h0000, 1'b0);

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].bin, vecs[i].e1, vecs[i].e0, vecs[i].eo,
              $sformatf("vec%0d", i));
    end

    // Start pulses while busy are ignored
    @(negedge clk_100mhz);
    drive(1'b1, 14'd321);
    @(posedge clk_100mhz);
    #1;
    drive(1'b0, 14'd999);
    dn = 0;
    for (int k = 1; k <= 40; k++) begin
      drive((k == 3 || k == 10), 14'd999);
      @(posedge clk_100mhz);
      #1;
      if (if1.done) dn++;
    end
    drive(1'b0, 14'd0);
    chk("ign done count", 32'(dn), 32'd1);
    chk_out("ign", 16'hF321, 16'h0321, 1'b0);

    // Start held high: back-to-back conversions
    @(negedge clk_100mhz);
    drive(1'b1, 14'd1234);
    @(posedge clk_100mhz);
    #1;
    drive(1'b1, 14'd56);
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (if1.done) begin
        if (d1 == 0) begin
          d1 = k;
          chk_out("b2b first", 16'h1234, 16'h1234, 1'b0);
        end else if (d2 == 0) begin
          d2 = k;
          chk_out("b2b second", 16'hFF56, 16'h0056, 1'b0);
          drive(1'b0, 14'd0);
        end
      end
    end
    drive(1'b0, 14'd0);
    chk("b2b first edge", 32'(d1), 32'd15);
    chk("b2b second edge", 32'(d2), 32'd31);
    repeat (20) @(posedge clk_100mhz);

    // Leave ovf set, then abort a conversion with reset
    convert(14'd12000, 16'hFFFF, 16'hFFFF, 1'b1, "pre-abort");
    @(negedge clk_100mhz);
    drive(1'b1, 14'd5678);
    @(posedge clk_100mhz);
    #1;
    drive(1'b0, 14'd0);
    repeat (5) @(posedge clk_100mhz);
    #1;
    reset = 1'b1;
    @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    dn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (if1.done || if0.done) dn++;
    end
    chk("abort done count", 32'(dn), 32'd0);
    chk("abort busy", 32'(if1.busy), 32'd0);
    chk_out("abort", 16'hFFF0, 16'h0000, 1'b0);
    convert(14'd5678, 16'h5678, 16'h5678, 1'b0, "post-abort");

    // Reset and start together: start dropped
    @(negedge clk_100mhz);
    drive(1'b1, 14'd77);
    reset = 1'b1;
    @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    drive(1'b0, 14'd0);
    chk("rst+start busy", 32'(if1.busy), 32'd0);
    dn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (if1.done) dn++;
    end
    chk("rst+start done count", 32'(dn), 32'd0);
    chk_out("rst+start", 16'hFFF0, 16'h0000, 1'b0);
    convert(14'd9090, 16'h9090, 16'h9090, 1'b0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
